// File: rtl/sync_fifo_pkg.sv
// Shared defaults and a depth helper for the synchronous FIFO slice.
package sync_fifo_pkg;

  localparam int unsigned data_size_dflt  = 8;
  localparam int unsigned depth_log2_dflt = 2;

  // Number of storage slots for a given pointer width.
  function automatic int unsigned fifo_depth(input int unsigned lg);
    return 32'd1 << lg;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of the synchronous FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned data_size  = data_size_dflt,
  parameter int unsigned depth_log2 = depth_log2_dflt
);

  logic                  wr_en;
  logic [data_size-1:0]  wr_data;
  logic                  rd_en;
  logic [data_size-1:0]  rd_data;
  logic                  full;
  logic                  empty;
  logic [depth_log2:0]   count;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side, drives requests.
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, full, empty, count, overflow, underflow
  );

  // FIFO side, answers requests.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_parallel_counter.sv
// Loadable up/down counter; simultaneous inc and dec cancel out.
module sync_parallel_counter #(
  parameter int unsigned     size       = 2,
  parameter logic [size-1:0] init_value = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic [size-1:0] load_value_i,
  input  logic            inc_enable_i,
  input  logic            dec_enable_i,
  output logic [size-1:0] value_o
);

  logic [size-1:0] value_q;
  logic [size-1:0] value_d;

  // Next value: load wins, otherwise net of inc/dec, wrapping modulo 2**size.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_value_i;
    end else if (inc_enable_i && !dec_enable_i) begin
      value_d = value_q + size'(1);
    end else if (dec_enable_i && !inc_enable_i) begin
      value_d = value_q - size'(1);
    end
  end

  // Counter register with synchronous reset to the initial value.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= init_value;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, acceptance logic and three counters for pointers/occupancy.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned data_size  = data_size_dflt,
  parameter int unsigned depth_log2 = depth_log2_dflt
) (
  input logic        clock,
  input logic        reset,
  sync_fifo_if.slave bus
);

  localparam int unsigned depth = fifo_depth(depth_log2);
  localparam int unsigned cnt_w = depth_log2 + 1;

  logic [data_size-1:0]  mem_q [depth];
  logic [depth_log2-1:0] wr_ptr_q;
  logic [depth_log2-1:0] rd_ptr_q;
  logic [cnt_w-1:0]      count_q;

  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc;
  logic                  rd_acc;

  logic [data_size-1:0]  rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  // Status flags and acceptance; a full FIFO still takes a write when a read frees a slot.
  always_comb begin
    full_c      = (count_q == cnt_w'(depth));
    empty_c     = (count_q == '0);
    wr_acc      = bus.wr_en & (~full_c | bus.rd_en);
    rd_acc      = bus.rd_en & ~empty_c;
    rd_data_d   = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    overflow_d  = bus.wr_en & ~wr_acc;
    underflow_d = bus.rd_en & ~rd_acc;
  end

  sync_parallel_counter #(.size(depth_log2), .init_value('0)) u_wr_ptr (
    .clock        (clock),
    .reset        (reset),
    .load_i       (1'b0),
    .load_value_i ('0),
    .inc_enable_i (wr_acc),
    .dec_enable_i (1'b0),
    .value_o      (wr_ptr_q)
  );

  sync_parallel_counter #(.size(depth_log2), .init_value('0)) u_rd_ptr (
    .clock        (clock),
    .reset        (reset),
    .load_i       (1'b0),
    .load_value_i ('0),
    .inc_enable_i (rd_acc),
    .dec_enable_i (1'b0),
    .value_o      (rd_ptr_q)
  );

  sync_parallel_counter #(.size(cnt_w), .init_value('0)) u_count (
    .clock        (clock),
    .reset        (reset),
    .load_i       (1'b0),
    .load_value_i ('0),
    .inc_enable_i (wr_acc),
    .dec_enable_i (rd_acc),
    .value_o      (count_q)
  );

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Registered read data and one-cycle reject pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
